// File: rtl/tl_mem_slave_pkg.sv
// Shared definitions for the TileLink-UL memory slave: channel A and channel D
// opcode encodings and the request FSM states.
package definitions;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } d_opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

endpackage

// File: rtl/tl_mem_slave_req_checker.sv
// Combinational request validity checker: flags out-of-range word addresses,
// sizes wider than the data bus and addresses misaligned to the access size.
// Only instantiated when TL_MEM_ERR_CHECK_EN is defined.
module tl_req_checker #(
    parameter int W         = 4,
    parameter int A         = 32,
    parameter int Z         = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic [Z-1:0] a_size_i,
    input  logic [A-1:0] a_address_i,
    output logic         err_o
);

    localparam int LW = $clog2(W);
    localparam int AW = $clog2(MEM_WORDS);

    // Any single violated rule marks the request as an error.
    always_comb begin
        err_o = 1'b0;
        if ((a_address_i >> (LW + AW)) != '0) err_o = 1'b1;
        if (a_size_i > Z'(LW)) err_o = 1'b1;
        for (int i = 0; i < LW; i++) begin
            if ((Z'(i) < a_size_i) && a_address_i[i]) err_o = 1'b1;
        end
    end

endmodule

// File: rtl/tl_mem_slave.sv
// TileLink-UL slave bridging single-beat Get / PutFullData / PutPartialData
// onto a single-port SRAM with one-cycle read latency. One request is in
// flight at a time: IDLE (accept + issue SRAM) -> ACCESS (capture read data)
// -> RESP (hold D until accepted).
// Optional feature macro: TL_MEM_ERR_CHECK_EN enables range, size and
// alignment error checks; without it the address wraps modulo MEM_WORDS.
module tl_mem_slave
    import definitions::*;
#(
    parameter int W         = 4,
    parameter int A         = 32,
    parameter int Z         = 32,
    parameter int O         = 1,
    parameter int I         = 1,
    parameter int SINK_ID   = 0,
    parameter int MEM_WORDS = 1024
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [2:0]                   a_opcode_i,
    input  logic [2:0]                   a_param_i,
    input  logic [Z-1:0]                 a_size_i,
    input  logic [O-1:0]                 a_source_i,
    input  logic [A-1:0]                 a_address_i,
    input  logic [W-1:0]                 a_mask_i,
    input  logic [8*W-1:0]               a_data_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    output logic [2:0]                   d_opcode_o,
    output logic [1:0]                   d_param_o,
    output logic [Z-1:0]                 d_size_o,
    output logic [O-1:0]                 d_source_o,
    output logic [I-1:0]                 d_sink_o,
    output logic [8*W-1:0]               d_data_o,
    output logic                         d_error_o,
    output logic                         d_valid_o,
    input  logic                         d_ready_i,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [W-1:0]                 mem_wmask_o,
    output logic [8*W-1:0]               mem_wdata_o,
    input  logic [8*W-1:0]               mem_rdata_i
);

    localparam int LW = $clog2(W);
    localparam int AW = $clog2(MEM_WORDS);

    state_e        state, state_nxt;
    logic          is_get, is_put, supported, req_err, accept;
    logic          req_get, req_err_q;
    logic [Z-1:0]  req_size;
    logic [O-1:0]  req_source;
    d_opcode_e     d_opcode_q;

    assign is_get    = (a_opcode_i == GET);
    assign is_put    = (a_opcode_i == PUT_FULL) || (a_opcode_i == PUT_PARTIAL);
    assign supported = is_get || is_put;

`ifdef TL_MEM_ERR_CHECK_EN
    logic range_err;

    tl_req_checker #(
        .W         (W),
        .A         (A),
        .Z         (Z),
        .MEM_WORDS (MEM_WORDS)
    ) u_req_checker (
        .a_size_i    (a_size_i),
        .a_address_i (a_address_i),
        .err_o       (range_err)
    );

    assign req_err = !supported || range_err;
`else
    assign req_err = !supported;
`endif

    // SRAM request is driven straight from channel A during the accept cycle.
    assign mem_addr_o  = a_address_i[LW +: AW];
    assign mem_wmask_o = (a_opcode_i == PUT_PARTIAL) ? a_mask_i : '1;
    assign mem_wdata_o = a_data_i;

    // Opcode param and the unused address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{a_param_i, a_address_i};

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and the combinational handshake / SRAM strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt = state;
        a_ready_o = 1'b0;
        accept    = 1'b0;
        mem_en_o  = 1'b0;
        mem_we_o  = 1'b0;
        case (state)
            IDLE: begin
                a_ready_o = !reset_i;
                if (a_valid_i && !reset_i) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                    mem_en_o  = !req_err;
                    mem_we_o  = !req_err && is_put;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    if (d_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request attributes at the A handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            req_get    <= 1'b0;
            req_err_q  <= 1'b0;
            req_size   <= '0;
            req_source <= '0;
        end else if (accept) begin
            req_get    <= is_get;
            req_err_q  <= req_err;
            req_size   <= a_size_i;
            req_source <= a_source_i;
        end
    end

    // Build the D response in ACCESS; it stays frozen through RESP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            d_opcode_q <= ACCESS_ACK;
            d_error_o  <= 1'b0;
            d_data_o   <= '0;
            d_size_o   <= '0;
            d_source_o <= '0;
        end else if (state == ACCESS) begin
            d_opcode_q <= req_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_error_o  <= req_err_q;
            d_data_o   <= (req_get && !req_err_q) ? mem_rdata_i : '0;
            d_size_o   <= req_size;
            d_source_o <= req_source;
        end
    end

    assign d_valid_o  = (state == RESP);
    assign d_opcode_o = d_opcode_q;
    assign d_param_o  = '0;
    assign d_sink_o   = I'(SINK_ID);

endmodule

// File: tb/tb_tl_mem_slave.sv
// Self-checking bench for tl_mem_slave: an SRAM behavioural responder, a
// word-level reference memory and per-request expected responses derived from
// the protocol rules. Directed cases first, then randomized traffic.
module tb_tl_mem_slave;

    localparam int W  = 4;
    localparam int A  = 32;
    localparam int Z  = 32;
    localparam int O  = 1;
    localparam int I  = 1;
    localparam int MW = 256;
    localparam int AW = $clog2(MW);

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic [2:0]      a_opcode_i = '0;
    logic [2:0]      a_param_i = '0;
    logic [Z-1:0]    a_size_i = '0;
    logic [O-1:0]    a_source_i = '0;
    logic [A-1:0]    a_address_i = '0;
    logic [W-1:0]    a_mask_i = '0;
    logic [8*W-1:0]  a_data_i = '0;
    logic            a_valid_i = 1'b0;
    logic            a_ready_o;
    logic [2:0]      d_opcode_o;
    logic [1:0]      d_param_o;
    logic [Z-1:0]    d_size_o;
    logic [O-1:0]    d_source_o;
    logic [I-1:0]    d_sink_o;
    logic [8*W-1:0]  d_data_o;
    logic            d_error_o;
    logic            d_valid_o;
    logic            d_ready_i = 1'b0;
    logic            mem_en_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [W-1:0]    mem_wmask_o;
    logic [8*W-1:0]  mem_wdata_o;
    logic [8*W-1:0]  mem_rdata_i = '0;

    tl_mem_slave #(
        .W(W), .A(A), .Z(Z), .O(O), .I(I), .SINK_ID(0), .MEM_WORDS(MW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .a_opcode_i(a_opcode_i), .a_param_i(a_param_i), .a_size_i(a_size_i),
        .a_source_i(a_source_i), .a_address_i(a_address_i), .a_mask_i(a_mask_i),
        .a_data_i(a_data_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .d_opcode_o(d_opcode_o), .d_param_o(d_param_o), .d_size_o(d_size_o),
        .d_source_o(d_source_o), .d_sink_o(d_sink_o), .d_data_o(d_data_o),
        .d_error_o(d_error_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM responder with a backdoor preload port; sole owner of sram[].
    logic [31:0]   sram [0:MW-1];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;
    logic [31:0]   sram_w;

    always @(posedge clk_i) begin
        if (bd_en) begin
            sram[bd_addr] = bd_data;
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                sram_w = sram[mem_addr_o];
                for (int b = 0; b < W; b++)
                    if (mem_wmask_o[b]) sram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                sram[mem_addr_o] = sram_w;
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    // Reference memory, updated only from the expected effect of requests.
    logic [31:0] ref_mem [0:MW-1];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, check the SRAM strobes at the handshake, the D
    // response two cycles later, its stability under `stall` cycles of
    // back-pressure and the return to ready afterwards.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] size, input logic src,
                          input logic [3:0] mask, input logic [31:0] data,
                          input int stall);
        int          word;
        bit          err, exp_en, exp_we, is_get;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
        int          waited;

        is_get = (op == 3'd4);
        err    = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
`ifdef TL_MEM_ERR_CHECK_EN
        if ((addr >> 2) >= MW) err = 1'b1;
        if (size > 2) err = 1'b1;
        else if ((addr % (32'd1 << size)) != 0) err = 1'b1;
`endif
        word     = int'((addr >> 2) % MW);
        exp_en   = !err;
        exp_we   = !err && !is_get;
        exp_mask = (op == 3'd0) ? 4'hF : mask;
        exp_data = (is_get && !err) ? ref_mem[word] : 32'h0;

        waited = 0;
        while (!a_ready_o && waited < 20) begin
            @(negedge clk_i);
            #1;
            waited++;
        end
        check("a_ready_wait", a_ready_o, 1'b1);

        a_opcode_i = op; a_address_i = addr; a_size_i = size; a_source_i = src;
        a_mask_i = mask; a_data_i = data; a_param_i = 3'($urandom); a_valid_i = 1'b1;
        #1;
        check("hs_mem_en", mem_en_o, exp_en);
        check("hs_mem_we", mem_we_o, exp_we);
        if (exp_en) check("hs_mem_addr", mem_addr_o, word[AW-1:0]);
        if (exp_we) begin
            check("hs_wmask", mem_wmask_o, exp_mask);
            check("hs_wdata", mem_wdata_o, data);
            for (int b = 0; b < W; b++)
                if (exp_mask[b]) ref_mem[word][8*b +: 8] = data[8*b +: 8];
        end
        @(posedge clk_i);
        @(negedge clk_i);
        a_valid_i = 1'b0;
        #1;
        check("access_a_ready", a_ready_o, 1'b0);
        check("access_d_valid", d_valid_o, 1'b0);
        @(negedge clk_i);
        for (int k = 0; k <= stall; k++) begin
            d_ready_i = (k == stall);
            #1;
            check("resp_d_valid", d_valid_o, 1'b1);
            check("resp_a_ready", a_ready_o, 1'b0);
            check("resp_opcode", d_opcode_o, is_get ? 3'd1 : 3'd0);
            check("resp_error", d_error_o, err);
            check("resp_data", d_data_o, exp_data);
            check("resp_size", d_size_o, size);
            check("resp_source", d_source_o, src);
            check("resp_param_sink", {d_param_o, d_sink_o}, 3'd0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        d_ready_i = 1'b0;
        #1;
        check("post_d_valid", d_valid_o, 1'b0);
        check("post_a_ready", a_ready_o, 1'b1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr, size;
        int          sel;

        // Preload SRAM and reference while reset is held; a request on A
        // during reset must not reach the SRAM.
        a_valid_i = 1'b1; a_opcode_i = 3'd4; a_size_i = 32'd2;
        for (int i = 0; i < MW; i++) begin
            @(negedge clk_i);
            bd_en = 1'b1; bd_addr = AW'(i);
            bd_data = (i == 4) ? 32'hDEADBEEF : $urandom;
            ref_mem[i] = bd_data;
        end
        @(negedge clk_i);
        bd_en = 1'b0;
        #1;
        check("rst_a_ready", a_ready_o, 1'b0);
        check("rst_d_valid", d_valid_o, 1'b0);
        check("rst_d_error", d_error_o, 1'b0);
        check("rst_d_data", d_data_o, 32'h0);
        check("rst_d_opcode", d_opcode_o, 3'd0);
        check("rst_mem_en", mem_en_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        a_valid_i = 1'b0;
        reset_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_exit_a_ready", a_ready_o, 1'b1);

        // Directed cases.
        do_req(3'd4, 32'h10, 32'd2, 1'b1, 4'hF, 32'h0, 0);
        do_req(3'd1, 32'h8, 32'd2, 1'b0, 4'b0011, 32'h12345678, 0);
        do_req(3'd4, 32'h8, 32'd2, 1'b0, 4'hF, 32'h0, 5);
        do_req(3'd4, 32'h2, 32'd2, 1'b1, 4'hF, 32'h0, 1);
        do_req(3'd2, 32'h4, 32'd2, 1'b0, 4'hF, 32'hCAFEF00D, 0);
        do_req(3'd0, 32'hFC, 32'd2, 1'b1, 4'h0, 32'hA5A5A5A5, 2);
        do_req(3'd4, 32'hFC, 32'd2, 1'b0, 4'h0, 32'h0, 0);

        // Reset during ACCESS drops the request without a D response.
        a_opcode_i = 3'd4; a_address_i = 32'h20; a_size_i = 32'd2; a_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        a_valid_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("midrst_d_valid", d_valid_o, 1'b0);
        check("midrst_a_ready", a_ready_o, 1'b0);
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            #1;
            check("midrst_no_resp", d_valid_o, 1'b0);
            check("midrst_idle", a_ready_o, 1'b1);
        end

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      op = 3'd4;
            else if (sel < 6) op = 3'd0;
            else if (sel < 8) op = 3'd1;
            else              op = 3'($urandom);
            addr = $urandom_range(0, 32'h7FF);
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            size = ($urandom_range(0, 3) != 0) ? 32'd2 : 32'($urandom_range(0, 3));
            do_req(op, addr, size, 1'($urandom), 4'($urandom), $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
